seg7_reader: RTL and testbench
==============================

// Module: seg7_reader
// PURPOSE
//  Receiving end of the 7-segment display bus: samples an 8-bit Dgfedcba segment
//  pattern and decodes it back to a 4-bit hex digit plus decimal point.
//  Filters glitches by requiring a stable pattern before accepting it.
//  Flags patterns that are not valid hex glyphs, and counts accepted decodes.
//  Sits between a segment driver (or its loop-back pins) and the LED/debug outputs.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive identical CE-qualified samples needed to accept (2..255)
//  CNT_W          8  width of DEC_CNT
// PORTS
//  C        in   1      clock, rising edge
//  CLR      in   1      reset, asynchronous, active-high
//  CE       in   1      clock enable; low = block frozen
//  SEG_IN   in   8      segment pattern, bit7 = D (decimal point), bits6..0 = g..a, 1 = lit
//  DIGIT    out  4      last accepted hex digit
//  DP       out  1      decimal point of last accepted pattern
//  BLANK    out  1      last accepted pattern had bits6..0 = 0
//  VALID    out  1      one-cycle strobe: new pattern accepted
//  ERR      out  1      last accepted pattern is not a legal glyph (sticky until next accept)
//  DEC_CNT  out  CNT_W  number of accepts with ERR=0 and BLANK=0, wraps to 0
// BEHAVIOUR
//  Reset (CLR=1, async): DIGIT=0, DP=0, BLANK=1, VALID=0, ERR=0, DEC_CNT=0,
//   sample reg=8'h00, run counter=0, state=IDLE. Effective mid-operation; no VALID is
//   generated for a pattern that was settling when CLR rose.
//  CE=0: all registers hold; VALID forced 0 in that cycle (no strobe is lost or repeated).
//  Sampling (CE=1, each rising C): samp <= SEG_IN; run <= (SEG_IN==samp) ? sat(run+1) : 0.
//  States:
//   IDLE   -> SETTLE on the first CE edge after reset.
//   SETTLE -> LOCKED on the edge where run reaches STABLE_CYCLES-1 (the STABLE_CYCLES-th
//             identical sample); outputs update and VALID=1 on that same edge.
//   LOCKED -> SETTLE on any edge where SEG_IN != samp; outputs hold; no strobe.
//   LOCKED and SEG_IN == samp: stay LOCKED, no further VALID.
//  Latency: pattern held from CE edge k is accepted at edge k+STABLE_CYCLES-1.
//  A pattern that returns to the locked value after a glitch is re-accepted (new VALID).
//  Decode of bits6..0 (hex): 3F=0 06=1 5B=2 4F=3 66=4 6D=5 7D=6 07=7 7F=8 6F=9
//   77=A 7C=b 39=C 5E=d 79=E 71=F; 00 -> BLANK=1, ERR=0, DIGIT holds.
//   Any other value -> ERR=1, BLANK=0, DIGIT holds previous value, VALID still strobes.
//  DP = bit7 of accepted pattern, independent of decode result.
//  DEC_CNT increments by 1 on VALID when ERR=0 and BLANK=0; 2^CNT_W-1 -> 0.
//  Run counter saturates at STABLE_CYCLES-1; no wrap for long stable inputs.
// TESTING
//  CLR pulse mid-settle (SEG_IN=8'h06 held 2 edges) -> all outputs at reset values at once,
//   no VALID; after release, VALID fires 4 edges later.
//  SEG_IN=8'h5B held, CE=1 -> VALID single pulse on 4th edge, DIGIT=2, DP=0, ERR=0, DEC_CNT=1.
//  SEG_IN=8'hEF -> DIGIT=9, DP=1; then 8'h12 held -> VALID, ERR=1, DIGIT stays 9, DEC_CNT unchanged.
//  8'h4F with 1-cycle glitch to 8'h4E every 3rd edge -> no VALID ever; glitch removed -> accept DIGIT=3.
//  CE toggled 1/0 each cycle with 8'h71 held -> VALID after 4 CE-high edges, DIGIT=F, 1-cycle pulse.
//  256 accepts alternating 8'h3F/8'h06 -> DEC_CNT wraps to 0; 8'h00 accept -> BLANK=1, count held.

Source files
------------

// File: rtl/seg7_if.sv
// Segment-bus bundle between a 7-segment pattern source and the reader that decodes it.
// The master side drives CE/SEG_IN; the slave side returns the decoded digit and status.
interface seg7_if #(
    parameter int CNT_W = 8
);
    logic             CE;
    logic [7:0]       SEG_IN;
    logic [3:0]       DIGIT;
    logic             DP;
    logic             BLANK;
    logic             VALID;
    logic             ERR;
    logic [CNT_W-1:0] DEC_CNT;

    modport master (
        output CE, SEG_IN,
        input  DIGIT, DP, BLANK, VALID, ERR, DEC_CNT
    );

    modport slave (
        input  CE, SEG_IN,
        output DIGIT, DP, BLANK, VALID, ERR, DEC_CNT
    );
endinterface

// File: rtl/seg7_reader.sv
// Decodes a Dgfedcba segment pattern back to a hex digit once it has been stable for
// STABLE_CYCLES enabled samples; flags illegal glyphs and counts good decodes.
module seg7_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic  C,
    input  logic  CLR,
    seg7_if.slave bus
);
    localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

    state_t           state, state_nx;
    logic [7:0]       samp, run, run_nx;
    logic             match, accept;
    logic [4:0]       dec;
    logic [3:0]       digit_q;
    logic             dp_q, blank_q, valid_q, err_q;
    logic [CNT_W-1:0] cnt_q;

    // Returns {legal, digit}; 7'h00 is reported as not legal and handled as blank.
    function automatic logic [4:0] decode(input logic [6:0] g);
        case (g)
            7'h3F: decode = {1'b1, 4'h0};
            7'h06: decode = {1'b1, 4'h1};
            7'h5B: decode = {1'b1, 4'h2};
            7'h4F: decode = {1'b1, 4'h3};
            7'h66: decode = {1'b1, 4'h4};
            7'h6D: decode = {1'b1, 4'h5};
            7'h7D: decode = {1'b1, 4'h6};
            7'h07: decode = {1'b1, 4'h7};
            7'h7F: decode = {1'b1, 4'h8};
            7'h6F: decode = {1'b1, 4'h9};
            7'h77: decode = {1'b1, 4'hA};
            7'h7C: decode = {1'b1, 4'hB};
            7'h39: decode = {1'b1, 4'hC};
            7'h5E: decode = {1'b1, 4'hD};
            7'h79: decode = {1'b1, 4'hE};
            7'h71: decode = {1'b1, 4'hF};
            default: decode = {1'b0, 4'h0};
        endcase
    endfunction

    assign dec = decode(bus.SEG_IN[6:0]);

    // The run counter saturates so a long stable input never wraps into a fresh accept.
    always_comb begin
        match  = (bus.SEG_IN == samp);
        run_nx = '0;
        if (match)
            run_nx = (run == RUN_MAX) ? run : run + 8'd1;
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // NOTE: every output of a combinational block gets a default first, otherwise an
    // unassigned path infers a latch.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        if (bus.CE) begin
            case (state)
                IDLE:   state_nx = SETTLE;
                SETTLE: if (match && run_nx == RUN_MAX) begin
                    state_nx = LOCKED;
                    accept   = 1'b1;
                end
                LOCKED: if (!match) state_nx = SETTLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            samp    <= '0;
            run     <= '0;
            digit_q <= '0;
            dp_q    <= 1'b0;
            blank_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= accept;
            if (bus.CE) begin
                samp <= bus.SEG_IN;
                run  <= run_nx;
            end
            if (accept) begin
                dp_q <= bus.SEG_IN[7];
                if (bus.SEG_IN[6:0] == 7'h00) begin
                    blank_q <= 1'b1;
                    err_q   <= 1'b0;
                end else if (dec[4]) begin
                    digit_q <= dec[3:0];
                    blank_q <= 1'b0;
                    err_q   <= 1'b0;
                    cnt_q   <= cnt_q + CNT_W'(1);
                end else begin
                    blank_q <= 1'b0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.DIGIT   = digit_q;
    assign bus.DP      = dp_q;
    assign bus.BLANK   = blank_q;
    assign bus.VALID   = valid_q;
    assign bus.ERR     = err_q;
    assign bus.DEC_CNT = cnt_q;
endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: fixed vector table, corner-case sequences, and random
// patterns compared against a stability/glyph-lookup reference model.
module tb_seg7_reader;
    localparam int S     = 4;
    localparam int CNT_W = 8;

    logic clk;
    logic clr;
    int   n_checks = 0;
    int   n_err    = 0;

    seg7_if #(.CNT_W(CNT_W)) bus ();

    seg7_reader #(.STABLE_CYCLES(S), .CNT_W(CNT_W)) dut (
        .C   (clk),
        .CLR (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: counts consecutive identical enabled samples of the input.
    logic [7:0] m_last;
    int         m_same;
    bit         m_started, m_locked;
    logic [3:0] m_digit;
    bit         m_dp, m_blank, m_err, m_valid;
    int         m_cnt;

    task automatic model_reset();
        m_last = 8'h00; m_same = 1; m_started = 0; m_locked = 0;
        m_digit = 4'h0; m_dp = 0; m_blank = 1; m_err = 0; m_valid = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic ce, input logic [7:0] seg);
        int d;
        m_valid = 0;
        if (!ce) return;
        m_same = (seg == m_last) ? m_same + 1 : 1;
        m_last = seg;
        if (!m_started) begin
            m_started = 1;
        end else if (m_locked) begin
            if (m_same == 1) m_locked = 0;
        end else if (m_same >= S) begin
            m_locked = 1;
            m_valid  = 1;
            m_dp     = seg[7];
            d = -1;
            for (int i = 0; i < 16; i++)
                if (glyph[i] == seg[6:0]) d = i;
            if (seg[6:0] == 7'h00) begin
                m_blank = 1; m_err = 0;
            end else if (d >= 0) begin
                m_digit = 4'(d); m_blank = 0; m_err = 0;
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end else begin
                m_blank = 0; m_err = 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_valid"}, 32'(bus.VALID),   32'(m_valid));
        check({tag, "_digit"}, 32'(bus.DIGIT),   32'(m_digit));
        check({tag, "_dp"},    32'(bus.DP),      32'(m_dp));
        check({tag, "_blank"}, 32'(bus.BLANK),   32'(m_blank));
        check({tag, "_err"},   32'(bus.ERR),     32'(m_err));
        check({tag, "_cnt"},   32'(bus.DEC_CNT), 32'(m_cnt));
    endtask

    task automatic drive(input logic ce, input logic [7:0] seg);
        bus.CE     = ce;
        bus.SEG_IN = seg;
        @(posedge clk);
        model_step(ce, seg);
        #1;
    endtask

    task automatic do_reset();
        clr    = 1'b1;
        bus.CE = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        clr = 1'b0;
        compare_model("reset");
    endtask

    typedef struct {
        logic       ce;
        logic [7:0] seg;
        logic       valid;
        logic [3:0] digit;
        logic       dp, blank, err;
        logic [7:0] cnt;
    } vec_t;

    function automatic vec_t v(int ce, int seg, int val, int dg, int dp, int bl, int er, int cnt);
        vec_t r;
        r.ce = ce[0]; r.seg = seg[7:0]; r.valid = val[0]; r.digit = dg[3:0];
        r.dp = dp[0]; r.blank = bl[0]; r.err = er[0]; r.cnt = cnt[7:0];
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [7:0] cur;
        int         seen, hit_edge;

        clr = 1'b1; bus.CE = 1'b0; bus.SEG_IN = 8'h00;
        model_reset();

        // ce, seg, valid, digit, dp, blank, err, cnt
        for (int i = 0; i < 3; i++) tbl.push_back(v(1, 'h5B, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(1, 'h5B, 1, 2, 0, 0, 0, 1));
        tbl.push_back(v(1, 'h5B, 0, 2, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(v(1, 'hEF, 0, 2, 0, 0, 0, 1));
        tbl.push_back(v(1, 'hEF, 1, 9, 1, 0, 0, 2));
        for (int i = 0; i < 3; i++) tbl.push_back(v(1, 'h12, 0, 9, 1, 0, 0, 2));
        tbl.push_back(v(1, 'h12, 1, 9, 0, 0, 1, 2));
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(v(1, 'h71, 0, 9, 0, 0, 1, 2));
            tbl.push_back(v(0, 'h71, 0, 9, 0, 0, 1, 2));
        end
        tbl.push_back(v(1, 'h71, 1, 15, 0, 0, 0, 3));
        tbl.push_back(v(0, 'h71, 0, 15, 0, 0, 0, 3));

        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].ce, tbl[i].seg);
            check($sformatf("tbl%0d_valid", i), 32'(bus.VALID),   32'(tbl[i].valid));
            check($sformatf("tbl%0d_digit", i), 32'(bus.DIGIT),   32'(tbl[i].digit));
            check($sformatf("tbl%0d_dp", i),    32'(bus.DP),      32'(tbl[i].dp));
            check($sformatf("tbl%0d_blank", i), 32'(bus.BLANK),   32'(tbl[i].blank));
            check($sformatf("tbl%0d_err", i),   32'(bus.ERR),     32'(tbl[i].err));
            check($sformatf("tbl%0d_cnt", i),   32'(bus.DEC_CNT), 32'(tbl[i].cnt));
        end

        // Glitch every third edge keeps the pattern from ever settling.
        seen = 0;
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, (i % 3 == 2) ? 8'h4E : 8'h4F);
            if (bus.VALID === 1'b1) seen++;
            compare_model("glitch");
        end
        check("glitch_no_valid", 32'(seen), 32'd0);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h4F);
        check("clean_before_valid", 32'(bus.VALID), 32'd0);
        drive(1'b1, 8'h4F);
        check("clean_valid", 32'(bus.VALID), 32'd1);
        check("clean_digit", 32'(bus.DIGIT), 32'd3);

        // Asynchronous reset while a new pattern is settling.
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h5B);
        for (int i = 0; i < 2; i++) drive(1'b1, 8'h06);
        #3;
        clr = 1'b1;
        model_reset();
        #1;
        compare_model("clr_async");
        check("clr_async_digit", 32'(bus.DIGIT), 32'd0);
        @(posedge clk);
        #1;
        check("clr_held_valid", 32'(bus.VALID), 32'd0);
        clr = 1'b0;
        hit_edge = 0;
        for (int e = 1; e <= 10 && hit_edge == 0; e++) begin
            drive(1'b1, 8'h06);
            compare_model("clr_rel");
            if (bus.VALID === 1'b1) hit_edge = e;
        end
        check("clr_rel_latency", 32'(hit_edge), 32'd4);

        // 256 good decodes wrap the counter; a blank accept leaves it alone.
        do_reset();
        for (int k = 0; k < 256; k++) begin
            for (int e = 0; e < 4; e++) drive(1'b1, (k % 2 == 1) ? 8'h06 : 8'h3F);
            compare_model("wrap");
        end
        check("wrap_cnt", 32'(bus.DEC_CNT), 32'd0);
        for (int e = 0; e < 4; e++) drive(1'b1, 8'h00);
        check("blank_valid", 32'(bus.VALID),   32'd1);
        check("blank_flag",  32'(bus.BLANK),   32'd1);
        check("blank_cnt",   32'(bus.DEC_CNT), 32'd0);
        check("blank_digit", 32'(bus.DIGIT),   32'd1);

        // Random patterns, hold lengths and clock enables against the model.
        cur = 8'h3F;
        for (int n = 0; n < 120; n++) begin
            int r, len;
            r = $urandom_range(0, 9);
            if (r < 6)       cur = {1'($urandom_range(0, 1)), glyph[$urandom_range(0, 15)]};
            else if (r == 6) cur = {1'($urandom_range(0, 1)), 7'h00};
            else if (r == 7) cur = 8'($urandom);
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                drive($urandom_range(0, 3) != 0, cur);
                compare_model("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
